terrain_heightmap: RTL
======================

# terrain_heightmap

Owns the destructible terrain shared by both players and all bombs. Stores one 9-bit surface row per screen column, streams the 480-bit terrain column mask for the current `DrawX` to the player colliders and bombs, and applies crater requests from bomb impacts via a valid/ready handshake. Sits between the bomb logic (writer) and every consumer of `terrain_data` (readers).

## Interface
- `COLS`, 640: number of screen columns / heightmap entries.
- `ROWS`, 480: column height; bit width of `terrain_data`.
- `HEIGHT_INIT`, 400: surface row written to every column during initialisation.
- `R_MAX`, 15: largest accepted crater radius.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `DrawX`  in  10  column being read.
- `terrain_data`  out  480  bit y = 1 iff row y is ground in column `DrawX`.
- `crater_valid`  in  1  crater request present.
- `crater_ready`  out  1  block can accept a request.
- `crater_x`  in  10  crater centre column.
- `crater_y`  in  10  crater centre row.
- `crater_r`  in  4  crater radius; values above `R_MAX` are clamped.
- `crater_done`  out  1  one-cycle pulse when a crater has been fully applied.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Heightmap entry `surf[c]` is in 0..480. Column mask bit y = (y >= `surf[c]`). A value of 480 means the column is empty.
- States:
  - INIT: writes `HEIGHT_INIT` to columns 0..639, one per cycle. Takes 640 cycles, then goes to IDLE.
  - IDLE: `crater_ready` = 1. On `crater_valid && crater_ready`, latch x, y, r, set `dx = -r` and go to RD.
  - RD: read `surf[x+dx]`.
  - WR: compute `h = chord(r,|dx|)` and `bot = y + h`.
    - If `surf <= bot`, write `min(bot+1, 480)`; otherwise leave the entry unchanged.
    - If `x+dx` is outside 0..639, suppress the write. The column still costs RD+WR.
    - If `dx == r`, go to IDLE and pulse `crater_done`. Otherwise `dx++` and go to RD.
- `chord(r,d) = floor(sqrt(r² − d²))`. Comes from a constant LUT; no run-time square root.
- Removal never exposes overhangs: everything above the crater bottom goes.
- Arithmetic:
  - Column index and `bot` use 11-bit signed arithmetic.
  - Negative or ≥640 columns are out of range.
  - `bot` is clamped before the 9-bit write.
- `crater_valid` outside IDLE is ignored; it is not queued. The requester must hold the request until it sees `crater_ready`.

## Timing
- Reset values:
  - Outputs: `terrain_data` = 0, `crater_ready` = 0, `crater_done` = 0, `busy` = 1.
  - Internal: state = INIT, init column = 0.
- Reset asserted mid-INIT or mid-carve: abort immediately, drop the in-flight crater, and restart INIT after release.
- Read path has 2-cycle latency:
  - `DrawX` is registered into the RAM address.
  - The RAM output is compared to form the mask, which is registered.
  - `terrain_data` therefore corresponds to `DrawX` from two edges earlier.
  - `DrawX` ≥ 640 yields all zeros.
- During INIT, `terrain_data` is forced to 0.
- Read/write collision on the same column: the read returns the old value.
- Crater latency: handshake cycle + 2·(2r+1) cycles. `crater_done` is asserted in the cycle the state returns to IDLE.
- Next accept is possible in the cycle after `crater_done`.

## Structure
- Package `terrain_pkg` holds:
  - the state enum (INIT, IDLE, RD, WR);
  - `COLS`, `ROWS`, `HEIGHT_INIT`, `R_MAX`;
  - the 16×16 `CHORD_LUT` constant (entries where d > r are 0).
- Sub-module `terrain_height_ram`: 640×9 simple dual-port RAM.
  - Port A: registered read.
  - Port B: write.
  - Read-before-write; inferrable to block RAM.

## Test plan
- Release reset, wait 640 cycles → `busy` falls; `DrawX` = 0 and 639 give bits 400..479 set, 0..399 clear.
- Crater (100, 400, r=3) → surf[97]=401, surf[98]=403, surf[100]=404, surf[103]=401, surf[96] unchanged at 400; `crater_done` fires 14 cycles after the accept.
- Crater (1, 400, r=3) → columns −2 and −1 are skipped with no RAM write and no wrap into 638/639; total latency is still 14 cycles.
- Crater (300, 478, r=5) → surf[300] = 480, so `DrawX` = 300 gives `terrain_data` = 0; surf[295] = 479.
- Hold `crater_valid` with a second request during a carve → it is accepted only in the cycle after `crater_done`; the first request's columns are not disturbed.
- Assert `reset` mid-carve → `crater_ready` = 0 and `busy` = 1 immediately; after release a full INIT runs and every column reads 400.

Source files
------------

// File: rtl/terrain_pkg.sv
// Shared constants, state encoding and chord table for the terrain heightmap.
// Latency: n/a (package only).
// Backpressure: n/a.
package terrain_pkg;

  localparam int COLS        = 640;
  localparam int ROWS        = 480;
  localparam int HEIGHT_INIT = 400;
  localparam int R_MAX       = 15;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RD,
    WR
  } carveState_t;

  // CHORD_LUT[r][d] = floor(sqrt(r*r - d*d)), 0 where d > r.
  // Each 64-bit row is one radius r; nibble d sits at bits [4d+3:4d].
  localparam logic [15:0][15:0][3:0] CHORD_LUT = {
    64'h0579_ABCC_DDEE_EEEF,  // r = 15
    64'h0057_89AB_CCDD_DDDE,  // r = 14
    64'h0005_689A_ABCC_CCCD,  // r = 13
    64'h0000_4678_9AAB_BBBC,  // r = 12
    64'h0000_0467_899A_AAAB,  // r = 11
    64'h0000_0046_7889_999A,  // r = 10
    64'h0000_0004_5678_8889,  // r = 9
    64'h0000_0000_3566_7778,  // r = 8
    64'h0000_0000_0345_6667,  // r = 7
    64'h0000_0000_0034_5556,  // r = 6
    64'h0000_0000_0003_4445,  // r = 5
    64'h0000_0000_0000_2334,  // r = 4
    64'h0000_0000_0000_0223,  // r = 3
    64'h0000_0000_0000_0012,  // r = 2
    64'h0000_0000_0000_0001,  // r = 1
    64'h0000_0000_0000_0000   // r = 0
  };

endpackage

// File: rtl/terrain_heightmap_if.sv
// Bus between the terrain heightmap, its column readers and the crater requester.
// Latency: n/a (wiring only).
// Backpressure: crater request is valid/ready; terrain_data stream has none.
// master: requester / reader side (drives DrawX and crater request).
// slave : terrain_heightmap side (drives terrain_data, ready, done, busy).
interface terrain_heightmap_if;
  import terrain_pkg::*;

  logic [9:0]      DrawX;
  logic [ROWS-1:0] terrain_data;
  logic            crater_valid;
  logic            crater_ready;
  logic [9:0]      crater_x;
  logic [9:0]      crater_y;
  logic [3:0]      crater_r;
  logic            crater_done;
  logic            busy;

  modport master (
    output DrawX, crater_valid, crater_x, crater_y, crater_r,
    input  terrain_data, crater_ready, crater_done, busy
  );

  modport slave (
    input  DrawX, crater_valid, crater_x, crater_y, crater_r,
    output terrain_data, crater_ready, crater_done, busy
  );

endinterface

// File: rtl/terrain_height_ram.sv
// Simple dual-port heightmap RAM: one registered read port, one write port.
// Latency: 1 cycle read; a same-cycle write to the read address returns the old value.
// Backpressure: none; accepts a read and a write every cycle.
// Ports: clk, wrEn/wrAddr/wrData (write), rdAddr/rdData (registered read).
module terrain_height_ram
  import terrain_pkg::*;
#(
  parameter int DEPTH = COLS,
  parameter int WIDTH = 9,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on the array or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wrEn && (wrAddr < AW'(DEPTH))) begin
      mem[wrAddr] <= wrData;
    end
    rdData <= (rdAddr < AW'(DEPTH)) ? mem[rdAddr] : '0;
  end

endmodule

// File: rtl/terrain_heightmap.sv
// Destructible terrain: per-column surface rows, column mask stream, crater carving.
// Latency: terrain_data 2 cycles after DrawX; crater done 2*(2r+1) cycles after accept.
// Backpressure: crater_ready only in IDLE; requests outside IDLE are ignored, not queued.
// Ports: clk, reset (async active-low), bus (slave side of terrain_heightmap_if).
module terrain_heightmap
  import terrain_pkg::*;
(
  input  logic clk,
  input  logic reset,
  terrain_heightmap_if.slave bus
);

  carveState_t       state;
  logic [9:0]        initCol;
  logic [9:0]        xReg;
  logic [9:0]        yReg;
  logic [3:0]        rReg;
  logic signed [4:0] dx;
  logic              craterReady;
  logic              craterDone;
  logic              busyReg;

  logic [3:0]         rSat;
  logic [3:0]         absDx;
  logic signed [11:0] col;
  logic               colInRange;
  logic [3:0]         chordH;
  logic [11:0]        bot;
  logic [8:0]         carveSurf;
  logic [8:0]         dispSurf;
  logic [8:0]         newSurf;
  logic               carveHit;
  logic               wrEn;
  logic [9:0]         wrAddr;
  logic [8:0]         wrData;

  logic               drawXInRange;
  logic [ROWS-1:0]    mask;

  // Two copies share every write: one serves the display read stream, the
  // other the carve read-modify-write, so carving never steals display reads.
  terrain_height_ram dispRam (
    .clk    (clk),
    .wrEn   (wrEn),
    .wrAddr (wrAddr),
    .wrData (wrData),
    .rdAddr (bus.DrawX),
    .rdData (dispSurf)
  );

  terrain_height_ram carveRam (
    .clk    (clk),
    .wrEn   (wrEn),
    .wrAddr (wrAddr),
    .wrData (wrData),
    .rdAddr (col[9:0]),
    .rdData (carveSurf)
  );

  always_comb begin
    rSat       = (bus.crater_r >= 4'(R_MAX)) ? 4'(R_MAX) : bus.crater_r;
    absDx      = dx[4] ? 4'(-dx) : dx[3:0];
    // Signed column so columns left of 0 are recognisable rather than wrapping.
    col        = $signed({2'b00, xReg}) + $signed({{7{dx[4]}}, dx});
    colInRange = !col[11] && (col[10:0] < 11'(COLS));
    chordH     = CHORD_LUT[rReg][absDx];
    bot        = {2'b00, yReg} + {8'b0, chordH};
    newSurf    = (bot >= 12'(ROWS - 1)) ? 9'(ROWS) : 9'(bot + 12'd1);
    // Surface at or above the crater bottom: everything down to bot goes,
    // which keeps the column free of overhangs.
    carveHit   = ({3'b000, carveSurf} <= bot);

    wrEn   = 1'b0;
    wrAddr = initCol;
    wrData = 9'(HEIGHT_INIT);
    if (state == INIT) begin
      wrEn = 1'b1;
    end else if ((state == WR) && colInRange && carveHit) begin
      wrEn   = 1'b1;
      wrAddr = col[9:0];
      wrData = newSurf;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= INIT;
      initCol     <= '0;
      xReg        <= '0;
      yReg        <= '0;
      rReg        <= '0;
      dx          <= '0;
      craterReady <= 1'b0;
      craterDone  <= 1'b0;
      busyReg     <= 1'b1;
    end else begin
      craterDone <= 1'b0;
      case (state)
        INIT: begin
          if (initCol == 10'(COLS - 1)) begin
            state       <= IDLE;
            craterReady <= 1'b1;
            busyReg     <= 1'b0;
          end else begin
            initCol <= initCol + 10'd1;
          end
        end
        IDLE: begin
          if (craterReady && bus.crater_valid) begin
            xReg        <= bus.crater_x;
            yReg        <= bus.crater_y;
            rReg        <= rSat;
            dx          <= -$signed({1'b0, rSat});
            state       <= RD;
            craterReady <= 1'b0;
            busyReg     <= 1'b1;
          end else begin
            // Ready is held low for the done cycle, so the next accept lands
            // one cycle after crater_done.
            craterReady <= 1'b1;
          end
        end
        RD: begin
          state <= WR;
        end
        WR: begin
          if (dx == $signed({1'b0, rReg})) begin
            state      <= IDLE;
            craterDone <= 1'b1;
            busyReg    <= 1'b0;
          end else begin
            dx    <= dx + 5'sd1;
            state <= RD;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Read pipeline: DrawX -> RAM read register -> mask register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drawXInRange <= 1'b0;
      mask         <= '0;
    end else begin
      drawXInRange <= (bus.DrawX < 10'(COLS));
      if ((state == INIT) || !drawXInRange) begin
        mask <= '0;
      end else begin
        // Bit y set iff y >= surface; a surface of 480 shifts everything out.
        mask <= {ROWS{1'b1}} << dispSurf;
      end
    end
  end

  assign bus.terrain_data = mask;
  assign bus.crater_ready = craterReady;
  assign bus.crater_done  = craterDone;
  assign bus.busy         = busyReg;

endmodule
